mem_access_stage: RTL and testbench

- Memory-access stage of the 5-stage MIPS pipeline, between the EX/ME pipeline register (upstream) and the ME/WB pipeline register (downstream).
- Performs load/store through a variable-latency request/acknowledge data-memory port.
- Stalls the pipeline while an access is outstanding.
- Presents {read data, ALU result, destination register, Mem2Reg, regWr} to the ME/WB register.

---
 rtl/mem_access_stage.sv | 138 +++++++++++++
 tb/tb_mem_access_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: request/ack data-memory port with pipeline stall and ME/WB outputs.
// Optional access timeout with sticky mem_err, enabled by defining MEM_TIMEOUT_EN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no access outstanding; a memop raises stall and starts ACCESS
// ACCESS | mem_req held until mem_ack (or timeout); stall held
// DONE   | read data valid on reg_out1, stall released for one cycle
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  dst_reg_in,
    input  logic        Ctrl_MemRd_in,
    input  logic        Ctrl_MemWr_in,
    input  logic        Ctrl_Mem2Reg_in,
    input  logic        Ctrl_regWr_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [31:0] reg_out1,
    output logic [31:0] reg_out2,
    output logic [4:0]  reg_out3,
    output logic        Ctrl_Mem2Reg_out,
    output logic        Ctrl_regWr_out,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] rdata_q;
    logic        memop;
    logic        in_access;
    logic        ack_hit;
    logic        timeout_hit;
    logic        stall_raw;

    assign memop     = Ctrl_MemRd_in | Ctrl_MemWr_in;
    assign in_access = (state == ACCESS);
    assign ack_hit   = in_access & mem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;
    logic       err_q;

    // An ack in the final cycle takes priority over the timeout.
    assign timeout_hit = in_access & ~mem_ack & (tmo_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && memop)
                tmo_cnt <= 8'd0;
            else if (in_access && !mem_ack)
                tmo_cnt <= tmo_cnt + 8'd1;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end

    assign mem_err = err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rdata_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (ack_hit)
                rdata_q <= Ctrl_MemWr_in ? 32'd0 : mem_rdata;
            else if (timeout_hit)
                rdata_q <= 32'hDEADBEEF;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_raw = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (state)
            IDLE: begin
                if (memop) begin
                    stall_raw = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                stall_raw = 1'b1;
                mem_req   = 1'b1;
                mem_we    = Ctrl_MemWr_in;
                mem_addr  = {alu_result_in[31:2], 2'b00};
                mem_wdata = store_data_in;
                if (ack_hit || timeout_hit)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset must also mask the IDLE+memop stall, which is decoded from live inputs.
    assign stall            = stall_raw & rst;
    assign reg_out1         = rdata_q;
    assign reg_out2         = alu_result_in;
    assign reg_out3         = dst_reg_in;
    assign Ctrl_Mem2Reg_out = Ctrl_Mem2Reg_in;
    assign Ctrl_regWr_out   = Ctrl_regWr_in & ~stall_raw & rst;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: per-cycle vector table plus reset/timeout sequences.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result_in, store_data_in, mem_rdata;
    logic [4:0]  dst_reg_in;
    logic        Ctrl_MemRd_in, Ctrl_MemWr_in, Ctrl_Mem2Reg_in, Ctrl_regWr_in, mem_ack;
    logic        mem_req, mem_we, stall, Ctrl_Mem2Reg_out, Ctrl_regWr_out, mem_err;
    logic [31:0] mem_addr, mem_wdata, reg_out1, reg_out2;
    logic [4:0]  reg_out3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in), .dst_reg_in(dst_reg_in),
        .Ctrl_MemRd_in(Ctrl_MemRd_in), .Ctrl_MemWr_in(Ctrl_MemWr_in),
        .Ctrl_Mem2Reg_in(Ctrl_Mem2Reg_in), .Ctrl_regWr_in(Ctrl_regWr_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .reg_out1(reg_out1), .reg_out2(reg_out2), .reg_out3(reg_out3),
        .Ctrl_Mem2Reg_out(Ctrl_Mem2Reg_out), .Ctrl_regWr_out(Ctrl_regWr_out), .mem_err(mem_err)
    );

    typedef struct {
        logic        rd, wr, m2r, rw, ack;
        logic [31:0] alu, sd, rdata;
        logic [4:0]  dst;
        logic        e_stall, e_req, e_we;
        logic [31:0] e_addr, e_wdata, e_r1;
        logic        e_rw;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t v(logic rd, logic wr, logic m2r, logic rw, logic ack,
                               logic [31:0] alu, logic [31:0] sd, logic [31:0] rdata, logic [4:0] dst,
                               logic e_stall, logic e_req, logic e_we, logic [31:0] e_addr,
                               logic [31:0] e_wdata, logic [31:0] e_r1, logic e_rw);
        vec_t t;
        t.rd = rd; t.wr = wr; t.m2r = m2r; t.rw = rw; t.ack = ack;
        t.alu = alu; t.sd = sd; t.rdata = rdata; t.dst = dst;
        t.e_stall = e_stall; t.e_req = e_req; t.e_we = e_we;
        t.e_addr = e_addr; t.e_wdata = e_wdata; t.e_r1 = e_r1; t.e_rw = e_rw;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic ack, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [31:0] rdata, input logic [4:0] dst);
        Ctrl_MemRd_in = rd; Ctrl_MemWr_in = wr; Ctrl_Mem2Reg_in = m2r; Ctrl_regWr_in = rw;
        mem_ack = ack; alu_result_in = alu; store_data_in = sd; mem_rdata = rdata; dst_reg_in = dst;
    endtask

    initial begin
        //            rd wr m2 rw ak alu           sd            rdata         dst   st rq we addr          wdata         r1            rwo
        vecs[0]  = v(0, 0, 0, 1, 0, 32'h00001234, 32'h0,        32'h0,        5'd5, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1);
        vecs[1]  = v(0, 0, 0, 1, 0, 32'h00001234, 32'h0,        32'h0,        5'd5, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1);
        vecs[2]  = v(1, 0, 1, 1, 0, 32'h00001007, 32'h11111111, 32'h0,        5'd7, 1, 0, 0, 32'h0,        32'h0,        32'h0,        0);
        vecs[3]  = v(1, 0, 1, 1, 1, 32'h00001007, 32'h11111111, 32'hCAFEF00D, 5'd7, 1, 1, 0, 32'h00001004, 32'h11111111, 32'h0,        0);
        vecs[4]  = v(1, 0, 1, 1, 0, 32'h00001007, 32'h11111111, 32'h0,        5'd7, 0, 0, 0, 32'h0,        32'h0,        32'hCAFEF00D, 1);
        vecs[5]  = v(0, 0, 0, 1, 1, 32'h00000040, 32'h0,        32'hBAD0BAD0, 5'd3, 0, 0, 0, 32'h0,        32'h0,        32'hCAFEF00D, 1);
        vecs[6]  = v(1, 1, 0, 0, 0, 32'h00003003, 32'h5A5A5A5A, 32'h0,        5'd0, 1, 0, 0, 32'h0,        32'h0,        32'hCAFEF00D, 0);
        vecs[7]  = v(1, 1, 0, 0, 1, 32'h00003003, 32'h5A5A5A5A, 32'hFFFFFFFF, 5'd0, 1, 1, 1, 32'h00003000, 32'h5A5A5A5A, 32'hCAFEF00D, 0);
        vecs[8]  = v(1, 1, 0, 0, 0, 32'h00003003, 32'h5A5A5A5A, 32'h0,        5'd0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0);
        vecs[9]  = v(0, 1, 0, 0, 0, 32'h00002002, 32'hA5A5A5A5, 32'h0,        5'd0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        0);
        vecs[10] = v(0, 1, 0, 0, 0, 32'h00002002, 32'hA5A5A5A5, 32'h0,        5'd0, 1, 1, 1, 32'h00002000, 32'hA5A5A5A5, 32'h0,        0);
        vecs[11] = v(0, 1, 0, 0, 0, 32'h00002002, 32'hA5A5A5A5, 32'h0,        5'd0, 1, 1, 1, 32'h00002000, 32'hA5A5A5A5, 32'h0,        0);
        vecs[12] = v(0, 1, 0, 0, 0, 32'h00002002, 32'hA5A5A5A5, 32'h0,        5'd0, 1, 1, 1, 32'h00002000, 32'hA5A5A5A5, 32'h0,        0);
        vecs[13] = v(0, 1, 0, 0, 1, 32'h00002002, 32'hA5A5A5A5, 32'h12345678, 5'd0, 1, 1, 1, 32'h00002000, 32'hA5A5A5A5, 32'h0,        0);
        vecs[14] = v(0, 1, 0, 0, 0, 32'h00002002, 32'hA5A5A5A5, 32'h0,        5'd0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0);

        // Reset held with a load pending on the inputs.
        rst = 1'b0;
        drive(1, 0, 1, 1, 0, 32'h00000100, 32'h0, 32'h0, 5'd1);
        #1;
        chk("rst req", {31'd0, mem_req}, 32'd0);
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst r1", reg_out1, 32'd0);
        chk("rst regwr", {31'd0, Ctrl_regWr_out}, 32'd0);
        chk("rst err", {31'd0, mem_err}, 32'd0);
        step();
        step();
        chk("rst hold req", {31'd0, mem_req}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rel stall", {31'd0, stall}, 32'd1);
        chk("rel req", {31'd0, mem_req}, 32'd0);
        step();
        chk("rel access req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("rel done stall", {31'd0, stall}, 32'd0);
        step();

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].m2r, vecs[i].rw, vecs[i].ack,
                  vecs[i].alu, vecs[i].sd, vecs[i].rdata, vecs[i].dst);
            #1;
            chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
            chk($sformatf("v%0d req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d wdata", i), mem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d r1", i), reg_out1, vecs[i].e_r1);
            chk($sformatf("v%0d r2", i), reg_out2, vecs[i].alu);
            chk($sformatf("v%0d r3", i), {27'd0, reg_out3}, {27'd0, vecs[i].dst});
            chk($sformatf("v%0d m2r", i), {31'd0, Ctrl_Mem2Reg_out}, {31'd0, vecs[i].m2r});
            chk($sformatf("v%0d regwr", i), {31'd0, Ctrl_regWr_out}, {31'd0, vecs[i].e_rw});
            step();
        end

        // Load to make rdata_q nonzero, then reset in the middle of a second load.
        drive(1, 0, 1, 1, 0, 32'h00000050, 32'h0, 32'h13579BDF, 5'd9);
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("pre r1", reg_out1, 32'h13579BDF);
        step();
        step();
        chk("mid req", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid rst req", {31'd0, mem_req}, 32'd0);
        chk("mid rst stall", {31'd0, stall}, 32'd0);
        chk("mid rst r1", reg_out1, 32'd0);
        step();
        drive(0, 0, 0, 1, 0, 32'h00000060, 32'h0, 32'hFFFF0000, 5'd2);
        rst = 1'b1;
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("stray req", {31'd0, mem_req}, 32'd0);
        chk("stray stall", {31'd0, stall}, 32'd0);
        chk("stray r1", reg_out1, 32'd0);
        step();
        chk("stray r1 late", reg_out1, 32'd0);
        chk("no err", {31'd0, mem_err}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // Ack in the last permitted cycle wins over the timeout.
        drive(1, 0, 1, 1, 0, 32'h00000070, 32'h0, 32'h00002468, 5'd4);
        step();
        for (int k = 0; k < 7; k++) step();
        chk("late ack req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("late ack r1", reg_out1, 32'h00002468);
        chk("late ack err", {31'd0, mem_err}, 32'd0);
        step();
        // No ack: eight ACCESS cycles then DONE with the error pattern.
        step();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("tmo req c%0d", k), {31'd0, mem_req}, 32'd1);
            step();
        end
        chk("tmo stall", {31'd0, stall}, 32'd0);
        chk("tmo r1", reg_out1, 32'hDEADBEEF);
        chk("tmo err", {31'd0, mem_err}, 32'd1);
        step();
        drive(1, 0, 1, 1, 0, 32'h00000080, 32'h0, 32'h0000ABCD, 5'd4);
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("tmo after r1", reg_out1, 32'h0000ABCD);
        chk("tmo sticky", {31'd0, mem_err}, 32'd1);
        rst = 1'b0;
        #1;
        chk("tmo rst err", {31'd0, mem_err}, 32'd0);
        rst = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
